// File: rtl/lbp_host_mem.sv
// Host-side responder for the LBP encoder: gray-image memory loaded through a
// valid/ready stream, read by the encoder, plus an LBP result memory with
// border filtering, write counting and read-back.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_LOAD   | accepting image pixels in raster order, ld_ready high
// S_SERVE  | image loaded; serving gray reads, capturing LBP writes
// S_DONE   | encoder finished; only read-back active, left by reset
module lbp_host_mem #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [DW-1:0] gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [DW-1:0] lbp_data,
  input  logic          finish,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          done,
  output logic [AW-1:0] wr_count,
  output logic          err_border,
  output logic          err_proto,
  output logic          err_count
);

  localparam int LW   = $clog2(IMG_W);
  localparam int RW   = AW - LW;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int NINT = (IMG_W - 2) * (IMG_H - 2);

  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
  localparam logic [AW-1:0] NINT_C   = AW'(NINT);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SERVE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ld_cnt_q, ld_cnt_d;
  logic            ld_ready_q, ld_ready_d;
  logic            gray_ready_q, gray_ready_d;
  logic [DW-1:0]   gray_data_q, gray_data_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            done_q, done_d;
  logic [AW-1:0]   wr_count_q, wr_count_d;
  logic            err_border_q, err_border_d;
  logic            err_proto_q, err_proto_d;
  logic            err_count_q, err_count_d;
  logic            gray_we;
  logic            lbp_we;

  logic [DW-1:0]   gray_mem [NPIX];
  logic [DW-1:0]   lbp_mem  [NPIX];

  // Outer ring of the image: first/last row or first/last column.
  function automatic logic is_border(input logic [AW-1:0] a);
    logic [RW-1:0] row;
    logic [LW-1:0] col;
    row = a[AW-1:LW];
    col = a[LW-1:0];
    return (row == '0) || (row == LAST_ROW) || (col == '0) || (col == '1);
  endfunction

  // Next-state, memory write enables and output register updates.
  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    ld_ready_d   = ld_ready_q;
    gray_ready_d = gray_ready_q;
    gray_data_d  = gray_data_q;
    done_d       = done_q;
    wr_count_d   = wr_count_q;
    err_border_d = err_border_q;
    err_proto_d  = err_proto_q;
    err_count_d  = err_count_q;
    gray_we      = 1'b0;
    lbp_we       = 1'b0;
    // Border read-back is masked so stale or never-written cells read as 0.
    rd_data_d    = is_border(rd_addr) ? '0 : lbp_mem[rd_addr];

    case (state_q)
      S_LOAD: begin
        ld_ready_d = 1'b1;
        if (ld_valid && ld_ready_q) begin
          gray_we  = 1'b1;
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == LAST_PIX) begin
            state_d      = S_SERVE;
            ld_ready_d   = 1'b0;
            gray_ready_d = 1'b1;
          end
        end
        if (lbp_valid || gray_req) err_proto_d = 1'b1;
      end
      S_SERVE: begin
        gray_ready_d = 1'b1;
        if (gray_req) gray_data_d = gray_mem[gray_addr];
        if (lbp_valid) begin
          if (is_border(lbp_addr)) begin
            err_border_d = 1'b1;
          end else begin
            lbp_we = 1'b1;
            if (wr_count_q != '1) wr_count_d = wr_count_q + 1'b1;
          end
        end
        // A write landing on the finish cycle is already in wr_count_d.
        if (finish) begin
          state_d      = S_DONE;
          done_d       = 1'b1;
          gray_ready_d = 1'b0;
          err_count_d  = (wr_count_d != NINT_C);
        end
      end
      S_DONE: begin
        if (lbp_valid || gray_req) err_proto_d = 1'b1;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LOAD;
      ld_cnt_q     <= '0;
      ld_ready_q   <= 1'b0;
      gray_ready_q <= 1'b0;
      gray_data_q  <= '0;
      rd_data_q    <= '0;
      done_q       <= 1'b0;
      wr_count_q   <= '0;
      err_border_q <= 1'b0;
      err_proto_q  <= 1'b0;
      err_count_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ld_cnt_q     <= ld_cnt_d;
      ld_ready_q   <= ld_ready_d;
      gray_ready_q <= gray_ready_d;
      gray_data_q  <= gray_data_d;
      rd_data_q    <= rd_data_d;
      done_q       <= done_d;
      wr_count_q   <= wr_count_d;
      err_border_q <= err_border_d;
      err_proto_q  <= err_proto_d;
      err_count_q  <= err_count_d;
    end
  end

  // Gray image memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (gray_we) gray_mem[ld_cnt_q] <= ld_data;
  end

  // LBP result memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (lbp_we) lbp_mem[lbp_addr] <= lbp_data;
  end

  assign ld_ready   = ld_ready_q;
  assign gray_ready = gray_ready_q;
  assign gray_data  = gray_data_q;
  assign rd_data    = rd_data_q;
  assign done       = done_q;
  assign wr_count   = wr_count_q;
  assign err_border = err_border_q;
  assign err_proto  = err_proto_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_lbp_host_mem.sv
// Directed bench for lbp_host_mem: load, serve, border handling, early finish,
// protocol errors, mid-load reset and a full interior frame.
module tb_lbp_host_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        gray_ready;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic [13:0] rd_addr;
  logic [7:0]  rd_data;
  logic        done;
  logic [13:0] wr_count;
  logic        err_border;
  logic        err_proto;
  logic        err_count;

  int checks = 0;
  int errors = 0;

  lbp_host_mem dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr),
    .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish), .rd_addr(rd_addr), .rd_data(rd_data),
    .done(done), .wr_count(wr_count), .err_border(err_border),
    .err_proto(err_proto), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lbp_write(input int a, input logic [7:0] d, input logic fin);
    lbp_valid = 1'b1;
    lbp_addr  = 14'(a);
    lbp_data  = d;
    finish    = fin;
    tick();
    lbp_valid = 1'b0;
    finish    = 1'b0;
  endtask

  // Streams nbeats pixels (ramp or inverted ramp) with occasional valid gaps.
  task automatic load_image(input bit inv, input int nbeats, input bit check_end);
    int cnt = 0;
    int cyc = 0;
    logic acc;
    while (cnt < nbeats && cyc < nbeats + 100) begin
      ld_valid = ((cyc % 997) != 500);
      ld_data  = inv ? ~8'(cnt) : 8'(cnt);
      acc      = ld_valid && ld_ready;
      if (check_end && acc && cnt == nbeats - 1) begin
        checks++;
        if (gray_ready !== 1'b0) begin
          errors++;
          $display("FAIL gray_ready_early: got %b expected 0", gray_ready);
        end
      end
      tick();
      cyc++;
      if (acc) cnt++;
    end
    ld_valid = 1'b0;
    checks++;
    if (cnt != nbeats) begin
      errors++;
      $display("FAIL load_beats: got %0d expected %0d", cnt, nbeats);
    end
    if (check_end) begin
      checks++;
      if (gray_ready !== 1'b1) begin
        errors++;
        $display("FAIL gray_ready_after_load: got %b expected 1", gray_ready);
      end
      checks++;
      if (ld_ready !== 1'b0) begin
        errors++;
        $display("FAIL ld_ready_after_load: got %b expected 0", ld_ready);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ld_valid = 1'b0; ld_data = '0; gray_req = 1'b0; gray_addr = '0;
    lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0; finish = 1'b0; rd_addr = 14'd129;
    tick(); tick();
    checks++;
    if ({ld_ready, gray_ready, done, err_border, err_proto, err_count} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {ld_ready, gray_ready, done, err_border, err_proto, err_count});
    end
    checks++;
    if (gray_data !== 8'h00 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h/%h expected 00/00", gray_data, rd_data);
    end
    checks++;
    if (wr_count !== 14'd0) begin
      errors++;
      $display("FAIL reset_wr_count: got %0d expected 0", wr_count);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL ld_ready_post_reset: got %b expected 1", ld_ready);
    end
  endtask

  task automatic test_load();
    load_image(1'b0, 16384, 1'b1);
    gray_req = 1'b1; gray_addr = 14'd129;
    tick();
    checks++;
    if (gray_data !== 8'h81) begin
      errors++;
      $display("FAIL gray_read_129: got %h expected 81", gray_data);
    end
    gray_addr = 14'd16383;
    tick();
    checks++;
    if (gray_data !== 8'hFF) begin
      errors++;
      $display("FAIL gray_read_last: got %h expected ff", gray_data);
    end
    gray_req = 1'b0; gray_addr = 14'd5;
    tick();
    checks++;
    if (gray_data !== 8'hFF) begin
      errors++;
      $display("FAIL gray_hold: got %h expected ff", gray_data);
    end
  endtask

  task automatic test_interior_write();
    lbp_write(129, 8'hA5, 1'b0);
    rd_addr = 14'd129;
    tick();
    checks++;
    if (rd_data !== 8'hA5) begin
      errors++;
      $display("FAIL rd_129: got %h expected a5", rd_data);
    end
    checks++;
    if (wr_count !== 14'd1 || err_border !== 1'b0) begin
      errors++;
      $display("FAIL first_write_status: got cnt=%0d border=%b expected cnt=1 border=0",
               wr_count, err_border);
    end
  endtask

  task automatic test_border();
    lbp_write(0, 8'h11, 1'b0);
    checks++;
    if (err_border !== 1'b1) begin
      errors++;
      $display("FAIL err_border_addr0: got %b expected 1", err_border);
    end
    lbp_write(255, 8'h22, 1'b0);
    lbp_write(16261, 8'h33, 1'b0);
    lbp_write(640, 8'h44, 1'b0);
    checks++;
    if (wr_count !== 14'd1) begin
      errors++;
      $display("FAIL border_no_count: got %0d expected 1", wr_count);
    end
    rd_addr = 14'd0;
    tick();
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL rd_border_0: got %h expected 00", rd_data);
    end
    rd_addr = 14'd255;
    tick();
    checks++;
    if (rd_data !== 8'h00) begin
      errors++;
      $display("FAIL rd_border_255: got %h expected 00", rd_data);
    end
    checks++;
    if (err_proto !== 1'b0) begin
      errors++;
      $display("FAIL err_proto_serve: got %b expected 0", err_proto);
    end
  endtask

  // 99 more writes (130..228) with finish on the last, giving 100 in total.
  task automatic test_short_finish();
    for (int a = 130; a <= 228; a++) lbp_write(a, 8'(a) ^ 8'h5A, a == 228);
    checks++;
    if (done !== 1'b1 || err_count !== 1'b1 || gray_ready !== 1'b0) begin
      errors++;
      $display("FAIL short_finish: got done=%b errc=%b gr=%b expected 1 1 0",
               done, err_count, gray_ready);
    end
    checks++;
    if (wr_count !== 14'd100) begin
      errors++;
      $display("FAIL short_wr_count: got %0d expected 100", wr_count);
    end
    lbp_write(129, 8'h11, 1'b0);
    gray_req = 1'b1; gray_addr = 14'd0;
    rd_addr = 14'd129;
    tick();
    gray_req = 1'b0;
    checks++;
    if (err_proto !== 1'b1) begin
      errors++;
      $display("FAIL err_proto_done: got %b expected 1", err_proto);
    end
    checks++;
    if (rd_data !== 8'hA5 || wr_count !== 14'd100) begin
      errors++;
      $display("FAIL done_write_ignored: got rd=%h cnt=%0d expected a5 100", rd_data, wr_count);
    end
    checks++;
    if (gray_data !== 8'hFF) begin
      errors++;
      $display("FAIL gray_hold_done: got %h expected ff", gray_data);
    end
    rd_addr = 14'd228;
    tick();
    checks++;
    if (rd_data !== 8'hBE) begin
      errors++;
      $display("FAIL rd_228: got %h expected be", rd_data);
    end
  endtask

  task automatic test_reset_mid_load();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || err_proto !== 1'b0 || err_count !== 1'b0 || wr_count !== 14'd0) begin
      errors++;
      $display("FAIL reset_after_done: got done=%b ep=%b ec=%b cnt=%0d expected 0 0 0 0",
               done, err_proto, err_count, wr_count);
    end
    load_image(1'b1, 5000, 1'b0);
    reset = 1'b1;
    tick();
    checks++;
    if (gray_ready !== 1'b0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_load_reset: got gr=%b lr=%b expected 0 0", gray_ready, ld_ready);
    end
    reset = 1'b0;
    tick();
    load_image(1'b1, 16384, 1'b1);
    gray_req = 1'b1; gray_addr = 14'd0;
    tick();
    checks++;
    if (gray_data !== 8'hFF) begin
      errors++;
      $display("FAIL reload_addr0: got %h expected ff", gray_data);
    end
    gray_addr = 14'd5000;
    tick();
    gray_req = 1'b0;
    checks++;
    if (gray_data !== 8'h77) begin
      errors++;
      $display("FAIL reload_addr5000: got %h expected 77", gray_data);
    end
  endtask

  task automatic test_full_frame();
    for (int r = 1; r <= 126; r++) begin
      for (int c = 1; c <= 126; c++) begin
        lbp_valid = 1'b1;
        lbp_addr  = 14'(r * 128 + c);
        lbp_data  = 8'(r * 128 + c) ^ 8'h3C;
        finish    = (r == 126 && c == 126);
        tick();
      end
    end
    lbp_valid = 1'b0;
    finish    = 1'b0;
    checks++;
    if (done !== 1'b1 || err_count !== 1'b0 || gray_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_finish: got done=%b errc=%b gr=%b expected 1 0 0",
               done, err_count, gray_ready);
    end
    checks++;
    if (wr_count !== 14'd15876) begin
      errors++;
      $display("FAIL full_wr_count: got %0d expected 15876", wr_count);
    end
    checks++;
    if (err_border !== 1'b0 || err_proto !== 1'b0) begin
      errors++;
      $display("FAIL full_err_flags: got eb=%b ep=%b expected 0 0", err_border, err_proto);
    end
    rd_addr = 14'd129;
    tick();
    checks++;
    if (rd_data !== 8'hBD) begin
      errors++;
      $display("FAIL full_rd_129: got %h expected bd", rd_data);
    end
    rd_addr = 14'd16254;
    tick();
    checks++;
    if (rd_data !== 8'h42) begin
      errors++;
      $display("FAIL full_rd_16254: got %h expected 42", rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_interior_write();
    test_border();
    test_short_finish();
    test_reset_mid_load();
    test_full_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
